id_hazard_controller: RTL and testbench

//  Sequences the decode stage: decides each cycle whether the instruction in ID issues, stalls or is squashed.

---
 rtl/id_hazard_controller_pkg.sv | 20 ++
 rtl/id_hazard_controller_hazard_match.sv | 20 ++
 rtl/id_hazard_controller.sv | 132 +++++++++++++
 tb/tb_id_hazard_controller.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/id_hazard_controller_pkg.sv
// Shared types for the decode-stage hazard controller: shadow pipeline slot
// record and FSM state encodings.
package id_hazard_controller_pkg;

  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    logic      vld;
    reg_addr_t rd;
    logic      ld;
  } slot_t;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/id_hazard_controller_hazard_match.sv
// Compares the ID source fields against one shadow slot; x0 never matches.
// need_ld restricts the hit to slots that hold a load (load-use only mode).
module id_hazard_controller_hazard_match
  import id_hazard_controller_pkg::*;
(
  input  logic      need_ld,
  input  reg_addr_t rs1,
  input  reg_addr_t rs2,
  input  logic      use_rs1,
  input  logic      use_rs2,
  input  slot_t     slot,
  output logic      match
);

  logic src_hit;

  assign src_hit = (use_rs1 && (rs1 == slot.rd)) || (use_rs2 && (rs2 == slot.rd));
  assign match   = slot.vld && (slot.rd != '0) && src_hit && (!need_ld || slot.ld);

endmodule

// File: rtl/id_hazard_controller.sv
// Decode-stage issue/stall/squash sequencer with boot flush, shadow
// scoreboard of in-flight destinations and a saturating stall counter.
module id_hazard_controller
  import id_hazard_controller_pkg::*;
#(
  parameter int FORWARDING  = 1,
  parameter int BOOT_CYCLES = 2,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             ex_redirect,
  output logic             stall_F,
  output logic             stall_D,
  output logic             flush_D,
  output logic             flush_E,
  output logic             booting,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);
  localparam logic       FWD_ON    = (FORWARDING != 0);

  state_t     state;
  logic [3:0] boot_cnt;
  logic       booting_q;
  slot_t      ex_slot, mem_slot, wb_slot;
  logic       m_ex, m_mem, m_wb;
  logic       hz;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Boot sequencer: the counter restarts on every reset assertion
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_BOOT;
      boot_cnt  <= '0;
      booting_q <= 1'b1;
    end else begin
      case (state)
        ST_BOOT: begin
          if (boot_cnt == BOOT_LAST) begin
            state     <= ST_RUN;
            booting_q <= 1'b0;
          end else begin
            boot_cnt <= boot_cnt + 4'd1;
          end
        end
        ST_RUN:  state <= ST_RUN;
        default: begin
          state     <= ST_BOOT;
          booting_q <= 1'b1;
        end
      endcase
    end
  end

  assign booting = booting_q;

  // With forwarding only a load sitting in EX can hurt; without it any slot can
  id_hazard_controller_hazard_match u_match_ex (
    .need_ld(FWD_ON), .rs1(id_rs1), .rs2(id_rs2), .use_rs1(id_use_rs1),
    .use_rs2(id_use_rs2), .slot(ex_slot), .match(m_ex)
  );
  id_hazard_controller_hazard_match u_match_mem (
    .need_ld(1'b0), .rs1(id_rs1), .rs2(id_rs2), .use_rs1(id_use_rs1),
    .use_rs2(id_use_rs2), .slot(mem_slot), .match(m_mem)
  );
  id_hazard_controller_hazard_match u_match_wb (
    .need_ld(1'b0), .rs1(id_rs1), .rs2(id_rs2), .use_rs1(id_use_rs1),
    .use_rs2(id_use_rs2), .slot(wb_slot), .match(m_wb)
  );

  assign hz = id_valid && (FWD_ON ? m_ex : (m_ex || m_mem || m_wb));

  always_comb begin
    stall_F = 1'b0;
    stall_D = 1'b0;
    flush_D = 1'b0;
    flush_E = 1'b0;
    if (state == ST_BOOT) begin
      stall_F = 1'b1;
      flush_D = 1'b1;
      flush_E = 1'b1;
    end else if (ex_redirect) begin
      flush_D = 1'b1;
      flush_E = 1'b1;
    end else if (hz) begin
      stall_F = 1'b1;
      stall_D = 1'b1;
      flush_E = 1'b1;
    end
  end

  // Shadow scoreboard: stalls and redirects enter EX as bubbles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_slot  <= '0;
      mem_slot <= '0;
      wb_slot  <= '0;
    end else if (state == ST_BOOT) begin
      ex_slot.vld  <= 1'b0;
      mem_slot.vld <= 1'b0;
      wb_slot.vld  <= 1'b0;
    end else begin
      wb_slot  <= mem_slot;
      mem_slot <= ex_slot;
      ex_slot  <= '{vld: id_valid && id_reg_write && !hz && !ex_redirect,
                    rd:  id_rd,
                    ld:  id_mem_read};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
    end else if (state == ST_RUN && stall_D) begin
      stall_count <= sat_inc(stall_count);
    end
  end

endmodule

// File: tb/tb_id_hazard_controller.sv
// Directed bench: one forwarding instance and one non-forwarding instance
// (2-bit counter to reach saturation) share clock, reset and ID inputs.
module tb_id_hazard_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_mem_read, ex_redirect;
  logic [4:0] id_rs1, id_rs2, id_rd;

  logic        fw_stall_F, fw_stall_D, fw_flush_D, fw_flush_E, fw_booting;
  logic [31:0] fw_count;
  logic        nf_stall_F, nf_stall_D, nf_flush_D, nf_flush_E, nf_booting;
  logic [1:0]  nf_count;
  logic [4:0]  fw_o, nf_o;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [4:0] O_IDLE  = 5'b00000;
  localparam logic [4:0] O_BOOT  = 5'b10111;
  localparam logic [4:0] O_STALL = 5'b11010;
  localparam logic [4:0] O_REDIR = 5'b00110;

  always #5 clk = ~clk;

  // {stall_F, stall_D, flush_D, flush_E, booting}
  assign fw_o = {fw_stall_F, fw_stall_D, fw_flush_D, fw_flush_E, fw_booting};
  assign nf_o = {nf_stall_F, nf_stall_D, nf_flush_D, nf_flush_E, nf_booting};

  id_hazard_controller #(.FORWARDING(1), .BOOT_CYCLES(2), .CNT_W(32)) u_fw (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .ex_redirect(ex_redirect),
    .stall_F(fw_stall_F), .stall_D(fw_stall_D), .flush_D(fw_flush_D),
    .flush_E(fw_flush_E), .booting(fw_booting), .stall_count(fw_count)
  );

  id_hazard_controller #(.FORWARDING(0), .BOOT_CYCLES(2), .CNT_W(2)) u_nf (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .ex_redirect(ex_redirect),
    .stall_F(nf_stall_F), .stall_D(nf_stall_D), .flush_D(nf_flush_D),
    .flush_E(nf_flush_E), .booting(nf_booting), .stall_count(nf_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic u1, input logic u2,
                       input logic rw, input logic mr, input logic redir);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_use_rs1 = u1; id_use_rs2 = u2; id_reg_write = rw; id_mem_read = mr;
    ex_redirect = redir;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic boot_release();
    tick();
    reset = 1'b0;
    chk("boot0_fw", 32'(fw_o), 32'(O_BOOT));
    tick();
    chk("boot1_fw", 32'(fw_o), 32'(O_BOOT));
    chk("boot1_nf", 32'(nf_o), 32'(O_BOOT));
    tick();
    chk("run_fw", 32'(fw_o), 32'(O_IDLE));
    chk("run_nf", 32'(nf_o), 32'(O_IDLE));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_out_fw", 32'(fw_o), 32'(O_BOOT));
    chk("rst_cnt_fw", fw_count, 32'd0);
    boot_release();

    // Load-use with forwarding: ld x5 ; add x6,x5,x7
    drive(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("ld_issue_fw", 32'(fw_o), 32'(O_IDLE));
    tick();
    drive(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("lu_stall_fw", 32'(fw_o), 32'(O_STALL));
    tick();
    chk("lu_issue_fw", 32'(fw_o), 32'(O_IDLE));
    chk("lu_cnt_fw", fw_count, 32'd1);
    tick();

    // x0 destination and unused source fields never stall
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd0, 5'd0, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("x0_fw", 32'(fw_o), 32'(O_IDLE));
    tick();
    drive(1'b1, 5'd2, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd8, 5'd8, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("nouse_fw", 32'(fw_o), 32'(O_IDLE));
    tick();

    // Redirect overrides a simultaneous load-use hazard
    drive(1'b1, 5'd2, 5'd0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd9, 5'd0, 5'd10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("redir_fw", 32'(fw_o), 32'(O_REDIR));
    tick();
    chk("redir_cnt_fw", fw_count, 32'd1);
    drive(1'b1, 5'd9, 5'd0, 5'd10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("post_redir_fw", 32'(fw_o), 32'(O_IDLE));

    // Fresh start for the non-forwarding checks
    reset = 1'b1;
    #1;
    chk("rst2_cnt_nf", 32'(nf_count), 32'd0);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    boot_release();

    // No forwarding: add x3,x1,x2 ; sub x4,x3,x1 stalls for EX, MEM, WB
    drive(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("add_issue_nf", 32'(nf_o), 32'(O_IDLE));
    tick();
    drive(1'b1, 5'd3, 5'd1, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("raw_fw_nostall", 32'(fw_o), 32'(O_IDLE));
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("raw_stall%0d_nf", i), 32'(nf_o), 32'(O_STALL));
      tick();
    end
    chk("raw_issue_nf", 32'(nf_o), 32'(O_IDLE));
    chk("raw_cnt_nf", 32'(nf_count), 32'd3);
    tick();

    // Counter saturates, then reset lands in the middle of a stall
    drive(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("lu2_stall_nf", 32'(nf_o), 32'(O_STALL));
    tick();
    chk("sat_cnt_nf", 32'(nf_count), 32'd3);
    chk("lu2_still_nf", 32'(nf_o), 32'(O_STALL));
    #2 reset = 1'b1;
    #1;
    chk("async_out_nf", 32'(nf_o), 32'(O_BOOT));
    chk("async_cnt_nf", 32'(nf_count), 32'd0);
    chk("async_cnt_fw", fw_count, 32'd0);
    boot_release();
    chk("shadow_empty_nf", 32'(nf_stall_D), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
